// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding, address map and grant encodings for the data-memory bus.
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] RAM_END = 32'h0000_00FF;
  localparam logic [31:0] IO_BASE = 32'h0000_0100;
  localparam logic [31:0] IO_END = 32'h0000_01FF;
  localparam logic [31:0] ADDR_LIMIT_DEF = IO_END;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0 = 2'b01;
  localparam logic [1:0] GNT_M1 = 2'b10;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way picker; round-robin on last grant, or m0 wins ties when fixed.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  input  logic       i_fixed_prio,
  output logic [1:0] o_gnt
);
  assign o_gnt[0] = i_req[0] & (~i_req[1] | i_fixed_prio | i_last_grant);
  assign o_gnt[1] = i_req[1] & ~o_gnt[0];
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises CPU (m0) and debug/DMA (m1) transactions onto the data bus with timeout and range check.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ADDR_LIMIT     = ADDR_LIMIT_DEF,
  parameter bit          FIXED_PRIO     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  output logic        o_m0_ready,
  output logic        o_m0_err,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_ready,
  output logic        o_m1_err,
  output logic [31:0] o_m1_rdata,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ack,
  output logic [1:0]  o_grant
);
  state_t      r_state;
  logic        r_last;
  logic [7:0]  r_cnt;
  logic [1:0]  r_grant;
  logic        r_bus_req, r_bus_we;
  logic [31:0] r_bus_addr, r_bus_wdata;
  logic        r_m0_ready, r_m0_err, r_m1_ready, r_m1_err;
  logic [31:0] r_m0_rdata, r_m1_rdata;
  logic [1:0]  w_gnt, w_own;
  logic        w_we, w_oor, w_tmo, w_fin, w_err;
  logic [31:0] w_addr, w_wdata, w_rdata;

  rr_arb2 u_arb (
    .i_req       ({i_m1_req, i_m0_req}),
    .i_last_grant(r_last),
    .i_fixed_prio(FIXED_PRIO),
    .o_gnt       (w_gnt)
  );

  assign w_we    = w_gnt[1] ? i_m1_we : i_m0_we;
  assign w_addr  = w_gnt[1] ? i_m1_addr : i_m0_addr;
  assign w_wdata = w_gnt[1] ? i_m1_wdata : i_m0_wdata;
  assign w_oor   = w_addr > ADDR_LIMIT;
  assign w_tmo   = r_cnt == 8'(TIMEOUT_CYCLES - 1);
  // A completion is either an out-of-range reject straight from IDLE or the end of a BUSY cycle
  assign w_fin   = (r_state == IDLE && |w_gnt && w_oor) || (r_state == BUSY && (i_bus_ack || w_tmo));
  assign w_own   = r_state == IDLE ? w_gnt : r_grant;
  assign w_err   = r_state == IDLE || !i_bus_ack;
  assign w_rdata = (r_state == BUSY && i_bus_ack && !r_bus_we) ? i_bus_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_grant     <= GNT_NONE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_m0_ready  <= 1'b0;
      r_m0_err    <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_ready  <= 1'b0;
      r_m1_err    <= 1'b0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_ready <= w_fin & w_own[0];
      r_m1_ready <= w_fin & w_own[1];
      r_m0_err   <= w_fin & w_own[0] & w_err;
      r_m1_err   <= w_fin & w_own[1] & w_err;
      if (w_fin && w_own[0]) r_m0_rdata <= w_rdata;
      if (w_fin && w_own[1]) r_m1_rdata <= w_rdata;
      case (r_state)
        IDLE: if (|w_gnt) begin
          r_grant     <= w_gnt;
          r_last      <= w_gnt[1];
          r_bus_addr  <= w_addr;
          r_bus_wdata <= w_wdata;
          r_bus_req   <= ~w_oor;
          r_bus_we    <= w_we & ~w_oor;
          r_state     <= w_oor ? DONE : BUSY;
        end
        BUSY: if (w_fin) begin
          r_bus_req <= 1'b0;
          r_bus_we  <= 1'b0;
          r_state   <= DONE;
        end else r_cnt <= r_cnt + 8'd1;
        DONE: begin
          r_state <= IDLE;
          r_grant <= GNT_NONE;
          r_cnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_m0_ready  = r_m0_ready;
  assign o_m0_err    = r_m0_err;
  assign o_m0_rdata  = r_m0_rdata;
  assign o_m1_ready  = r_m1_ready;
  assign o_m1_err    = r_m1_err;
  assign o_m1_rdata  = r_m1_rdata;
  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_grant     = r_grant;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of a round-robin arbiter (u0) and a fixed-priority one (u1).
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic [1:0] rst_n, m0_req, m0_we, m1_req, m1_we, bus_ack;
  logic [1:0][31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;
  wire  [1:0] m0_ready, m0_err, m1_ready, m1_err, bus_req, bus_we;
  wire  [1:0][31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
  wire  [1:0][1:0] grant;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(16), .ADDR_LIMIT(32'h0000_01FF), .FIXED_PRIO(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n[0]),
    .i_m0_req(m0_req[0]), .i_m0_we(m0_we[0]), .i_m0_addr(m0_addr[0]), .i_m0_wdata(m0_wdata[0]),
    .o_m0_ready(m0_ready[0]), .o_m0_err(m0_err[0]), .o_m0_rdata(m0_rdata[0]),
    .i_m1_req(m1_req[0]), .i_m1_we(m1_we[0]), .i_m1_addr(m1_addr[0]), .i_m1_wdata(m1_wdata[0]),
    .o_m1_ready(m1_ready[0]), .o_m1_err(m1_err[0]), .o_m1_rdata(m1_rdata[0]),
    .o_bus_req(bus_req[0]), .o_bus_we(bus_we[0]), .o_bus_addr(bus_addr[0]), .o_bus_wdata(bus_wdata[0]),
    .i_bus_rdata(bus_rdata[0]), .i_bus_ack(bus_ack[0]), .o_grant(grant[0])
  );

  mem_bus_arbiter #(.TIMEOUT_CYCLES(16), .ADDR_LIMIT(32'h0000_01FF), .FIXED_PRIO(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n[1]),
    .i_m0_req(m0_req[1]), .i_m0_we(m0_we[1]), .i_m0_addr(m0_addr[1]), .i_m0_wdata(m0_wdata[1]),
    .o_m0_ready(m0_ready[1]), .o_m0_err(m0_err[1]), .o_m0_rdata(m0_rdata[1]),
    .i_m1_req(m1_req[1]), .i_m1_we(m1_we[1]), .i_m1_addr(m1_addr[1]), .i_m1_wdata(m1_wdata[1]),
    .o_m1_ready(m1_ready[1]), .o_m1_err(m1_err[1]), .o_m1_rdata(m1_rdata[1]),
    .o_bus_req(bus_req[1]), .o_bus_we(bus_we[1]), .o_bus_addr(bus_addr[1]), .o_bus_wdata(bus_wdata[1]),
    .i_bus_rdata(bus_rdata[1]), .i_bus_ack(bus_ack[1]), .o_grant(grant[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n[0] = 1'b0;
    m0_req[0] = 1'b0;
    m1_req[0] = 1'b0;
    tick();
    tick();
    rst_n[0] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 2'b11;
    {m0_req, m0_we, m1_req, m1_we, bus_ack} = '0;
    {m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata} = '0;
    #2 rst_n = 2'b00;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++; if ({bus_req[d], bus_we[d], bus_addr[d], bus_wdata[d], grant[d], m0_ready[d], m0_err[d], m0_rdata[d], m1_ready[d], m1_err[d], m1_rdata[d]} !== '0) begin n_fail++; $display("FAIL reset_outputs u%0d: got nonzero outputs, expected all zero", d); end
    end
    rst_n = 2'b11;
  endtask

  task automatic test_load();
    m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 32'h10; bus_ack[0] = 1'b1; bus_rdata[0] = 32'hDEAD_BEEF;
    tick();
    n_tests++; if ({bus_req[0], grant[0], m0_ready[0]} !== 4'b1010) begin n_fail++; $display("FAIL load_busy: got req/grant/ready %b expected 1010", {bus_req[0], grant[0], m0_ready[0]}); end
    n_tests++; if (bus_addr[0] !== 32'h10) begin n_fail++; $display("FAIL load_addr: got %h expected 00000010", bus_addr[0]); end
    tick();
    n_tests++; if ({m0_ready[0], m0_err[0], bus_req[0]} !== 3'b100) begin n_fail++; $display("FAIL load_ready: got ready/err/bus_req %b expected 100", {m0_ready[0], m0_err[0], bus_req[0]}); end
    n_tests++; if (m0_rdata[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata: got %h expected deadbeef", m0_rdata[0]); end
    n_tests++; if ({m1_ready[0], m1_err[0], m1_rdata[0]} !== '0) begin n_fail++; $display("FAIL load_m1_quiet: got %h expected 0", {m1_ready[0], m1_err[0], m1_rdata[0]}); end
    m0_req[0] = 1'b0;
    tick();
    n_tests++; if ({m0_ready[0], grant[0]} !== 3'b000) begin n_fail++; $display("FAIL load_idle: got ready/grant %b expected 000", {m0_ready[0], grant[0]}); end
    n_tests++; if (m0_rdata[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata_hold: got %h expected deadbeef", m0_rdata[0]); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    m0_req[0] = 1'b1; m0_we[0] = 1'b1; m0_addr[0] = 32'h104; m0_wdata[0] = 32'hAAAA_0001;
    m1_req[0] = 1'b1; m1_we[0] = 1'b1; m1_addr[0] = 32'h108; m1_wdata[0] = 32'hBBBB_0002;
    bus_ack[0] = 1'b1; bus_rdata[0] = 32'h1111_2222;
    tick();
    n_tests++; if ({grant[0], bus_we[0], bus_addr[0], bus_wdata[0]} !== {2'b01, 1'b1, 32'h104, 32'hAAAA_0001}) begin n_fail++; $display("FAIL rr_first_m0: got grant %b we %b addr %h wdata %h", grant[0], bus_we[0], bus_addr[0], bus_wdata[0]); end
    tick();
    n_tests++; if ({m0_ready[0], m1_ready[0], m0_rdata[0]} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL rr_m0_write_done: got ready %b%b rdata %h expected 10 / 0", m0_ready[0], m1_ready[0], m0_rdata[0]); end
    m0_req[0] = 1'b0;
    tick();
    tick();
    n_tests++; if ({grant[0], bus_req[0], bus_we[0], bus_addr[0], bus_wdata[0]} !== {2'b10, 2'b11, 32'h108, 32'hBBBB_0002}) begin n_fail++; $display("FAIL rr_second_m1: got grant %b req %b we %b addr %h wdata %h", grant[0], bus_req[0], bus_we[0], bus_addr[0], bus_wdata[0]); end
    tick();
    n_tests++; if ({m1_ready[0], m1_err[0], m1_rdata[0]} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL rr_m1_write_done: got ready %b err %b rdata %h", m1_ready[0], m1_err[0], m1_rdata[0]); end
    m1_req[0] = 1'b0;
    m0_req[0] = 1'b1;
    tick();
    m1_req[0] = 1'b1;
    tick();
    n_tests++; if (grant[0] !== 2'b01) begin n_fail++; $display("FAIL rr_third_m0: got grant %b expected 01", grant[0]); end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 32'h200; bus_ack[0] = 1'b1;
    tick();
    n_tests++; if ({m0_ready[0], m0_err[0], bus_req[0], grant[0]} !== 5'b11001) begin n_fail++; $display("FAIL oor_reject: got ready/err/bus_req/grant %b expected 11001", {m0_ready[0], m0_err[0], bus_req[0], grant[0]}); end
    m0_req[0] = 1'b0;
    tick();
    n_tests++; if ({m0_ready[0], m0_err[0], bus_req[0], grant[0]} !== 5'b00000) begin n_fail++; $display("FAIL oor_clear: got %b expected 00000", {m0_ready[0], m0_err[0], bus_req[0], grant[0]}); end
    m0_req[0] = 1'b1; m0_we[0] = 1'b1; m0_addr[0] = 32'h1FF; m0_wdata[0] = 32'h0000_00FF;
    tick();
    n_tests++; if ({bus_req[0], bus_we[0]} !== 2'b11) begin n_fail++; $display("FAIL oor_edge_busy: got req/we %b expected 11", {bus_req[0], bus_we[0]}); end
    tick();
    n_tests++; if ({m0_ready[0], m0_err[0]} !== 2'b10) begin n_fail++; $display("FAIL oor_edge_done: got ready/err %b expected 10", {m0_ready[0], m0_err[0]}); end
    m0_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    logic seen;
    m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 32'h20; bus_ack[0] = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    n_tests++; if (bus_req[0] !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got bus_req %b expected 1", bus_req[0]); end
    rst_n[0] = 1'b0;
    m0_req[0] = 1'b0;
    #1;
    n_tests++; if ({bus_req[0], bus_we[0], bus_addr[0], bus_wdata[0], grant[0], m0_ready[0], m0_err[0], m0_rdata[0], m1_ready[0], m1_err[0], m1_rdata[0]} !== '0) begin n_fail++; $display("FAIL abort_async_zero: got nonzero outputs, expected all zero"); end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); seen |= m0_ready[0]; end
    rst_n[0] = 1'b1;
    tick();
    seen |= m0_ready[0];
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready: got m0_ready pulse %b expected 0", seen); end
    m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 32'h1F0; bus_ack[0] = 1'b1; bus_rdata[0] = 32'h1234_5678;
    tick();
    n_tests++; if ({grant[0], bus_req[0], bus_addr[0]} !== {3'b101, 32'h1F0}) begin n_fail++; $display("FAIL abort_m1_busy: got grant %b req %b addr %h", grant[0], bus_req[0], bus_addr[0]); end
    tick();
    n_tests++; if ({m1_ready[0], m1_err[0], m1_rdata[0]} !== {2'b10, 32'h1234_5678}) begin n_fail++; $display("FAIL abort_m1_done: got ready %b err %b rdata %h", m1_ready[0], m1_err[0], m1_rdata[0]); end
    m1_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int busy_cycles;
    m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 32'h100; bus_ack[0] = 1'b0; bus_rdata[0] = 32'hFFFF_FFFF;
    busy_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus_req[0] === 1'b1 && m1_ready[0] === 1'b0) busy_cycles++;
    end
    n_tests++; if (busy_cycles !== 16) begin n_fail++; $display("FAIL timeout_busy_len: got %0d busy cycles expected 16", busy_cycles); end
    tick();
    n_tests++; if ({bus_req[0], m1_ready[0], m1_err[0]} !== 3'b011) begin n_fail++; $display("FAIL timeout_abort: got req/ready/err %b expected 011", {bus_req[0], m1_ready[0], m1_err[0]}); end
    n_tests++; if (m1_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata: got %h expected 0", m1_rdata[0]); end
    m1_req[0] = 1'b0;
    tick();
    n_tests++; if ({m1_ready[0], m1_err[0], grant[0]} !== 4'b0000) begin n_fail++; $display("FAIL timeout_clear: got %b expected 0000", {m1_ready[0], m1_err[0], grant[0]}); end
  endtask

  task automatic test_fixed_prio();
    int m0_wins;
    m0_req[1] = 1'b1; m0_addr[1] = 32'h40; m1_req[1] = 1'b1; m1_addr[1] = 32'h80;
    bus_ack[1] = 1'b1; bus_rdata[1] = 32'h55AA_55AA;
    m0_wins = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (grant[1] === 2'b01) m0_wins++;
      tick();
      if ({m1_ready[1], m0_ready[1]} === 2'b01) m0_wins++;
      tick();
    end
    n_tests++; if (m0_wins !== 8) begin n_fail++; $display("FAIL fixed_m0_every_time: got %0d of 8 m0 grant/ready events", m0_wins); end
    n_tests++; if (m0_rdata[1] !== 32'h55AA_55AA) begin n_fail++; $display("FAIL fixed_m0_rdata: got %h expected 55aa55aa", m0_rdata[1]); end
    m0_req[1] = 1'b0;
    tick();
    n_tests++; if ({grant[1], bus_addr[1]} !== {2'b10, 32'h80}) begin n_fail++; $display("FAIL fixed_m1_after_drop: got grant %b addr %h expected 10 / 00000080", grant[1], bus_addr[1]); end
    tick();
    n_tests++; if ({m1_ready[1], m1_err[1], m1_rdata[1]} !== {2'b10, 32'h55AA_55AA}) begin n_fail++; $display("FAIL fixed_m1_done: got ready %b err %b rdata %h", m1_ready[1], m1_err[1], m1_rdata[1]); end
    m1_req[1] = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_round_robin();
    test_out_of_range();
    test_reset_mid_busy();
    test_timeout();
    test_fixed_prio();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
